// File: rtl/rpc_slot_queue_if.sv
// Request-slot queue bus: push/pop/initialize handshakes between the TX path and the slot store.
// Combinational bundle only (no latency); the slot store has no backpressure, failed ops raise error.
// occupancy_out exists only when RQ_OCCUPANCY_CHECK_EN is defined.
interface rpc_slot_queue_if #(
  parameter int DATA_WIDTH = 512,
  parameter int LSIZE      = 4
);
  logic                  push_en_in;
  logic [DATA_WIDTH-1:0] push_data_in;
  logic [LSIZE-1:0]      push_slot_id_out;
  logic                  push_done_out;
  logic                  pop_en_in;
  logic [LSIZE-1:0]      pop_slot_id_in;
  logic [DATA_WIDTH-1:0] pop_data_out;
  logic                  initialize;
  logic                  initialized;
  logic                  error;
`ifdef RQ_OCCUPANCY_CHECK_EN
  logic [LSIZE:0]        occupancy_out;
`endif

  modport slave (
    input  push_en_in, push_data_in, pop_en_in, pop_slot_id_in, initialize,
    output push_slot_id_out, push_done_out, pop_data_out, initialized, error
`ifdef RQ_OCCUPANCY_CHECK_EN
    , output occupancy_out
`endif
  );

  modport master (
    output push_en_in, push_data_in, pop_en_in, pop_slot_id_in, initialize,
    input  push_slot_id_out, push_done_out, pop_data_out, initialized, error
`ifdef RQ_OCCUPANCY_CHECK_EN
    , input occupancy_out
`endif
  );
endinterface

// File: rtl/rpc_slot_queue.sv
// Slot-addressed request store with a FIFO free-slot list built by an initialize sequence.
// Push done / pop data one cycle after the request; no backpressure, illegal ops set sticky error.
// Optional double-free protection and occupancy count: define RQ_OCCUPANCY_CHECK_EN.
module rpc_slot_queue #(
  parameter int DATA_WIDTH = 512,
  parameter int LSIZE      = 4
) (
  input  logic         clk,
  input  logic         resetn,
  rpc_slot_queue_if.slave bus
);

  localparam int NSLOTS = 2**LSIZE;
  localparam logic [LSIZE:0]   FL_FULL  = (LSIZE+1)'(NSLOTS);
  localparam logic [LSIZE-1:0] LAST_ID  = LSIZE'(NSLOTS - 1);

  typedef enum logic [1:0] {ST_UNINIT, ST_FILL, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [LSIZE-1:0]      init_cnt_q, init_cnt_d;
  logic [LSIZE-1:0]      fl_rd_q, fl_rd_d;
  logic [LSIZE-1:0]      fl_wr_q, fl_wr_d;
  logic [LSIZE:0]        fl_cnt_q, fl_cnt_d;
  logic                  initialized_q, initialized_d;
  logic                  error_q, error_d;
  logic                  push_done_q, push_done_d;
  logic [LSIZE-1:0]      push_id_q, push_id_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;

  // Storage arrays carry no reset: contents only become meaningful after init/push.
  logic [LSIZE-1:0]      fl_mem_q [NSLOTS];
  logic [DATA_WIDTH-1:0] ram_q    [NSLOTS];

  logic                  fl_we;
  logic [LSIZE-1:0]      fl_wr_id;
  logic                  ram_we;
  logic [LSIZE-1:0]      ram_wr_id;
  logic [LSIZE-1:0]      head_id;
  logic                  ready;
  logic                  push_ok;
  logic                  pop_rd;
  logic                  pop_ok;
  logic                  pop_slot_valid;

`ifdef RQ_OCCUPANCY_CHECK_EN
  logic [NSLOTS-1:0]     occ_q, occ_d;
  logic [LSIZE:0]        occ_cnt_q, occ_cnt_d;
`endif

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    fl_rd_d        = fl_rd_q;
    fl_wr_d        = fl_wr_q;
    fl_cnt_d       = fl_cnt_q;
    initialized_d  = initialized_q;
    error_d        = error_q;
    push_done_d    = 1'b0;
    push_id_d      = push_id_q;
    pop_data_d     = pop_data_q;
    fl_we          = 1'b0;
    fl_wr_id       = '0;
    ram_we         = 1'b0;
    ram_wr_id      = '0;

    ready   = (state_q == ST_READY);
    head_id = fl_mem_q[fl_rd_q];

`ifdef RQ_OCCUPANCY_CHECK_EN
    occ_d          = occ_q;
    occ_cnt_d      = occ_cnt_q;
    pop_slot_valid = occ_q[bus.pop_slot_id_in];
`else
    pop_slot_valid = 1'b1;
`endif

    // Push sees the pre-pop free count, so a same-cycle pop cannot rescue an empty list.
    push_ok = ready && bus.push_en_in && (fl_cnt_q != '0);
    pop_rd  = ready && bus.pop_en_in && (fl_cnt_q != FL_FULL);
    pop_ok  = pop_rd && pop_slot_valid;

    if ((bus.push_en_in && !push_ok) || (bus.pop_en_in && !pop_ok)) begin
      error_d = 1'b1;
    end

    case (state_q)
      ST_UNINIT: begin
        if (bus.initialize) begin
          state_d    = ST_FILL;
          init_cnt_d = '0;
        end
      end

      ST_FILL: begin
        fl_we      = 1'b1;
        fl_wr_id   = init_cnt_q;
        fl_wr_d    = fl_wr_q + 1'b1;
        fl_cnt_d   = fl_cnt_q + 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ID) begin
          state_d       = ST_READY;
          initialized_d = 1'b1;
        end
      end

      ST_READY: begin
        if (push_ok) begin
          fl_rd_d     = fl_rd_q + 1'b1;
          ram_we      = 1'b1;
          ram_wr_id   = head_id;
          push_id_d   = head_id;
          push_done_d = 1'b1;
        end
        // RAM is read from the registered array, so a same-slot write this cycle is not visible.
        if (pop_rd) begin
          pop_data_d = ram_q[bus.pop_slot_id_in];
        end
        if (pop_ok) begin
          fl_we    = 1'b1;
          fl_wr_id = bus.pop_slot_id_in;
          fl_wr_d  = fl_wr_q + 1'b1;
        end
        fl_cnt_d = fl_cnt_q + (LSIZE+1)'(pop_ok) - (LSIZE+1)'(push_ok);
`ifdef RQ_OCCUPANCY_CHECK_EN
        if (pop_ok) begin
          occ_d[bus.pop_slot_id_in] = 1'b0;
        end
        if (push_ok) begin
          occ_d[head_id] = 1'b1;
        end
        occ_cnt_d = occ_cnt_q + (LSIZE+1)'(push_ok) - (LSIZE+1)'(pop_ok);
`endif
      end

      default: state_d = ST_UNINIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_UNINIT;
      init_cnt_q    <= '0;
      fl_rd_q       <= '0;
      fl_wr_q       <= '0;
      fl_cnt_q      <= '0;
      initialized_q <= 1'b0;
      error_q       <= 1'b0;
      push_done_q   <= 1'b0;
      push_id_q     <= '0;
      pop_data_q    <= '0;
`ifdef RQ_OCCUPANCY_CHECK_EN
      occ_q         <= '0;
      occ_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      fl_rd_q       <= fl_rd_d;
      fl_wr_q       <= fl_wr_d;
      fl_cnt_q      <= fl_cnt_d;
      initialized_q <= initialized_d;
      error_q       <= error_d;
      push_done_q   <= push_done_d;
      push_id_q     <= push_id_d;
      pop_data_q    <= pop_data_d;
`ifdef RQ_OCCUPANCY_CHECK_EN
      occ_q         <= occ_d;
      occ_cnt_q     <= occ_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (fl_we) begin
      fl_mem_q[fl_wr_q] <= fl_wr_id;
    end
    if (ram_we) begin
      ram_q[ram_wr_id] <= bus.push_data_in;
    end
  end

  assign bus.push_slot_id_out = push_id_q;
  assign bus.push_done_out    = push_done_q;
  assign bus.pop_data_out     = pop_data_q;
  assign bus.initialized      = initialized_q;
  assign bus.error            = error_q;
`ifdef RQ_OCCUPANCY_CHECK_EN
  assign bus.occupancy_out    = occ_cnt_q;
`endif

endmodule

// File: tb/tb_rpc_slot_queue.sv
// Directed bench for rpc_slot_queue with LSIZE=2: vector table plus reset/init/occupancy sequences.
module tb_rpc_slot_queue;
  localparam int DW = 32;
  localparam int LS = 2;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rpc_slot_queue_if #(.DATA_WIDTH(DW), .LSIZE(LS)) bus ();

  rpc_slot_queue #(.DATA_WIDTH(DW), .LSIZE(LS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic          push;
    logic [DW-1:0] pdat;
    logic          pop;
    logic [LS-1:0] pid;
    logic          init;
    logic          done;
    logic [LS-1:0] id;
    logic [DW-1:0] pdo;
    logic          inited;
    logic          err;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic pu, input logic [DW-1:0] pd, input logic po,
                              input logic [LS-1:0] pi, input logic in, input logic dn,
                              input logic [LS-1:0] id, input logic [DW-1:0] pdo,
                              input logic ini, input logic er);
    vec_t v;
    v.push = pu; v.pdat = pd; v.pop = po; v.pid = pi; v.init = in;
    v.done = dn; v.id = id; v.pdo = pdo; v.inited = ini; v.err = er;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic pu, input logic [DW-1:0] pd, input logic po,
                      input logic [LS-1:0] pi, input logic in);
    @(negedge clk);
    bus.push_en_in     = pu;
    bus.push_data_in   = pd;
    bus.pop_en_in      = po;
    bus.pop_slot_id_in = pi;
    bus.initialize     = in;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #2;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Pulse initialize and measure cycles until initialized rises (bounded).
  task automatic do_init(input string nm);
    int found;
    found = -1;
    step(1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      idle();
      if (bus.initialized === 1'b1 && found < 0) found = k;
    end
    check(nm, 64'(found), 64'd4);
  endtask

  initial begin
    bus.push_en_in     = 1'b0;
    bus.push_data_in   = '0;
    bus.pop_en_in      = 1'b0;
    bus.pop_slot_id_in = '0;
    bus.initialize     = 1'b0;
    resetn             = 1'b0;

    //            push pdat     pop pid init | done id pdo      inited err
    tbl[0]  = mk(0, 32'h0,  0, 0, 1,  0, 0, 32'h0,  0, 0);
    tbl[1]  = mk(0, 32'h0,  0, 0, 0,  0, 0, 32'h0,  0, 0);
    tbl[2]  = mk(0, 32'h0,  0, 0, 0,  0, 0, 32'h0,  0, 0);
    tbl[3]  = mk(0, 32'h0,  0, 0, 0,  0, 0, 32'h0,  0, 0);
    tbl[4]  = mk(0, 32'h0,  0, 0, 0,  0, 0, 32'h0,  1, 0);
    tbl[5]  = mk(1, 32'hA,  0, 0, 0,  1, 0, 32'h0,  1, 0);
    tbl[6]  = mk(1, 32'hB,  0, 0, 0,  1, 1, 32'h0,  1, 0);
    tbl[7]  = mk(1, 32'hC,  0, 0, 0,  1, 2, 32'h0,  1, 0);
    tbl[8]  = mk(0, 32'h0,  1, 1, 0,  0, 2, 32'hB,  1, 0);
    tbl[9]  = mk(0, 32'h0,  1, 0, 0,  0, 2, 32'hA,  1, 0);
    tbl[10] = mk(1, 32'hD,  0, 0, 0,  1, 3, 32'hA,  1, 0);
    tbl[11] = mk(1, 32'hE,  0, 0, 0,  1, 1, 32'hA,  1, 0);
    tbl[12] = mk(1, 32'hF,  0, 0, 0,  1, 0, 32'hA,  1, 0);
    tbl[13] = mk(1, 32'h77, 0, 0, 0,  0, 0, 32'hA,  1, 1);
    tbl[14] = mk(1, 32'h44, 1, 2, 0,  0, 0, 32'hC,  1, 1);
    tbl[15] = mk(1, 32'h55, 0, 0, 0,  1, 2, 32'hC,  1, 1);
    tbl[16] = mk(0, 32'h0,  1, 2, 0,  0, 2, 32'h55, 1, 1);
    tbl[17] = mk(1, 32'h66, 1, 3, 0,  1, 2, 32'hD,  1, 1);
    tbl[18] = mk(1, 32'h88, 1, 3, 0,  1, 3, 32'hD,  1, 1);
    tbl[19] = mk(0, 32'h0,  1, 3, 0,  0, 3, 32'h88, 1, 1);

    #12;
    check("rst_done",   64'(bus.push_done_out),    64'd0);
    check("rst_id",     64'(bus.push_slot_id_out), 64'd0);
    check("rst_pdo",    64'(bus.pop_data_out),     64'd0);
    check("rst_inited", 64'(bus.initialized),      64'd0);
    check("rst_err",    64'(bus.error),            64'd0);
`ifdef RQ_OCCUPANCY_CHECK_EN
    check("rst_occ",    64'(bus.occupancy_out),    64'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].push, tbl[i].pdat, tbl[i].pop, tbl[i].pid, tbl[i].init);
      check($sformatf("vec%0d_done", i),   64'(bus.push_done_out),    64'(tbl[i].done));
      check($sformatf("vec%0d_id", i),     64'(bus.push_slot_id_out), 64'(tbl[i].id));
      check($sformatf("vec%0d_pdo", i),    64'(bus.pop_data_out),     64'(tbl[i].pdo));
      check($sformatf("vec%0d_inited", i), 64'(bus.initialized),      64'(tbl[i].inited));
      check($sformatf("vec%0d_err", i),    64'(bus.error),            64'(tbl[i].err));
    end

    // Asynchronous reset in the middle of operation clears everything immediately.
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("async_rst_done",   64'(bus.push_done_out),    64'd0);
    check("async_rst_id",     64'(bus.push_slot_id_out), 64'd0);
    check("async_rst_pdo",    64'(bus.pop_data_out),     64'd0);
    check("async_rst_inited", 64'(bus.initialized),      64'd0);
    check("async_rst_err",    64'(bus.error),            64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Push before initialize.
    step(1'b1, 32'h99, 1'b0, '0, 1'b0);
    check("preinit_push_done", 64'(bus.push_done_out), 64'd0);
    check("preinit_push_err",  64'(bus.error),         64'd1);

    // Reset part-way through FILL, then a full re-initialize.
    step(1'b0, '0, 1'b0, '0, 1'b1);
    idle();
    idle();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midfill_inited", 64'(bus.initialized), 64'd0);
    check("midfill_err",    64'(bus.error),       64'd0);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    check("uninit_stays", 64'(bus.initialized), 64'd0);
    do_init("reinit_latency");
    check("reinit_err", 64'(bus.error), 64'd0);

    // Pop while every slot is already free overflows the free list.
    step(1'b0, '0, 1'b1, 2'd1, 1'b0);
    check("overflow_pop_err", 64'(bus.error), 64'd1);
    step(1'b1, 32'h123, 1'b0, '0, 1'b0);
    check("after_overflow_done", 64'(bus.push_done_out),    64'd1);
    check("after_overflow_id",   64'(bus.push_slot_id_out), 64'd0);

`ifdef RQ_OCCUPANCY_CHECK_EN
    do_reset();
    do_init("occ_init_latency");
    step(1'b1, 32'h10, 1'b0, '0, 1'b0);
    step(1'b1, 32'h11, 1'b0, '0, 1'b0);
    step(1'b1, 32'h12, 1'b0, '0, 1'b0);
    check("occ_after_3push", 64'(bus.occupancy_out),    64'd3);
    check("occ_id2",         64'(bus.push_slot_id_out), 64'd2);
    step(1'b0, '0, 1'b1, 2'd2, 1'b0);
    check("occ_pop1_cnt", 64'(bus.occupancy_out), 64'd2);
    check("occ_pop1_err", 64'(bus.error),         64'd0);
    check("occ_pop1_pdo", 64'(bus.pop_data_out),  64'h12);
    step(1'b0, '0, 1'b1, 2'd2, 1'b0);
    check("occ_pop2_cnt", 64'(bus.occupancy_out), 64'd2);
    check("occ_pop2_err", 64'(bus.error),         64'd1);
    check("occ_pop2_pdo", 64'(bus.pop_data_out),  64'h12);
    step(1'b1, 32'h20, 1'b0, '0, 1'b0);
    check("occ_push_a_done", 64'(bus.push_done_out),    64'd1);
    check("occ_push_a_id",   64'(bus.push_slot_id_out), 64'd3);
    step(1'b1, 32'h21, 1'b0, '0, 1'b0);
    check("occ_push_b_done", 64'(bus.push_done_out),    64'd1);
    check("occ_push_b_id",   64'(bus.push_slot_id_out), 64'd2);
    step(1'b1, 32'h22, 1'b0, '0, 1'b0);
    check("occ_push_c_done", 64'(bus.push_done_out),    64'd0);
    check("occ_full_cnt",    64'(bus.occupancy_out),    64'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
